// File: rtl/enigma_pkg.sv
// Shared constants, FSM state type and the letter test for the Enigma
// key sequencer and its output register.
package enigma_pkg;

  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned SETTING_W = 2;
  localparam int unsigned COUNT_W   = 16;

  localparam logic [CHAR_W-1:0] ASCII_A = 8'h41;
  localparam logic [CHAR_W-1:0] ASCII_Z = 8'h5A;

  typedef enum logic {
    LOCKED = 1'b0,
    RUN    = 1'b1
  } state_e;

  // Only upper-case letters go through the cipher core and consume a key digit.
  function automatic logic is_letter(input logic [CHAR_W-1:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/enigma_key_sequencer_if.sv
// Character stream in / out handshakes of the Enigma key sequencer.
interface enigma_key_sequencer_if;
  import enigma_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W:1]   in_char;
  logic              out_valid;
  logic              out_ready;
  logic [CHAR_W:1]   out_char;

  modport slave (
    input  in_valid, in_char, out_ready,
    output in_ready, out_valid, out_char
  );

  modport master (
    output in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_char
  );

endinterface

// File: rtl/enigma_out_reg.sv
// One-entry valid/ready output register; data holds while valid && !ready.
module enigma_out_reg
  import enigma_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CHAR_W:1] load_char,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [CHAR_W:1] out_char
);

  logic            valid_q, valid_d;
  logic [CHAR_W:1] char_q,  char_d;

  // A load wins over a drain so a simultaneous drain+accept stays valid.
  always_comb begin
    valid_d = valid_q;
    char_d  = char_q;
    if (load) begin
      valid_d = 1'b1;
      char_d  = load_char;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      char_q  <= '0;
    end else begin
      valid_q <= valid_d;
      char_q  <= char_d;
    end
  end

  assign out_valid = valid_q;
  assign out_char  = char_q;

endmodule

// File: rtl/enigma_key_sequencer.sv
// Feeds characters to the cipher core with the current key digit, stepping
// one digit per letter, and registers the result for the downstream stage.
module enigma_key_sequencer
  import enigma_pkg::*;
#(
  parameter int unsigned KEY_LEN = 4,
  parameter int unsigned PTR_W   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_load,
  input  logic [2*KEY_LEN-1:0]      key_in,
  input  logic                      restart,
  enigma_key_sequencer_if.slave     io,
  output logic [CHAR_W:1]           core_char,
  output logic [SETTING_W-1:0]      core_setting,
  input  logic [CHAR_W:1]           core_result,
  output logic [COUNT_W-1:0]        letter_count
);

  state_e                                  state_q, state_d;
  logic [KEY_LEN-1:0][SETTING_W-1:0]       key_q,   key_d;
  logic [PTR_W-1:0]                        ptr_q,   ptr_d;
  logic [COUNT_W-1:0]                      cnt_q,   cnt_d;

  logic            out_valid_w;
  logic [CHAR_W:1] out_char_w;
  logic            in_ready_c;
  logic            accept_c;
  logic            letter_c;
  logic [CHAR_W:1] next_char_c;

  // Key control cycles block input so the first character after them sees digit 0.
  assign in_ready_c  = (state_q == RUN) && !key_load && !restart &&
                       (!out_valid_w || io.out_ready);
  assign accept_c    = io.in_valid && in_ready_c;
  assign letter_c    = is_letter(io.in_char);
  assign next_char_c = letter_c ? core_result : io.in_char;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (key_load) begin
      state_d = RUN;
      key_d   = key_in;
      ptr_d   = '0;
      cnt_d   = '0;
    end else if (restart) begin
      ptr_d   = '0;
    end else if (accept_c && letter_c) begin
      ptr_d = (ptr_q == PTR_W'(KEY_LEN - 1)) ? '0 : ptr_q + PTR_W'(1);
      if (cnt_q != '1) begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOCKED;
      key_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  enigma_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_c),
    .load_char (next_char_c),
    .out_ready (io.out_ready),
    .out_valid (out_valid_w),
    .out_char  (out_char_w)
  );

  assign io.in_ready    = in_ready_c;
  assign io.out_valid   = out_valid_w;
  assign io.out_char    = out_char_w;
  assign core_char      = io.in_char;
  assign core_setting   = key_q[ptr_q];
  assign letter_count   = cnt_q;

endmodule
